// File: rtl/joy_db15_if.sv
// Serial DB15 joystick link: shift clock and load strobe from the poller,
// serial data back from the adapter.
interface joy_db15_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// Target-side emulator of the serial DB15 joystick adapter: a 74HC165-style
// parallel-load shift chain clocked by the poller's asynchronous JOY_CLK/JOY_LOAD.

// Synchroniser, glitch filter and rising-edge detector for one idle-high pin.
module joy_db15_cond #(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic rise
);
  localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

  logic [1:0] sync_r;
  logic       lvl_d_r;
  logic       filt_s;

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], pin};
    end
  end

  generate
    if (FILT == 0) begin : g_bypass
      assign filt_s = sync_r[1];
    end else begin : g_filt
      logic          filt_r;
      logic [CW-1:0] cnt_r;

      // Adopt the synced level only after it has disagreed for FILT straight cycles.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          filt_r <= 1'b1;
          cnt_r  <= '0;
        end else if (sync_r[1] != filt_r) begin
          if (cnt_r == CW'(FILT - 1)) begin
            filt_r <= sync_r[1];
            cnt_r  <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end else begin
          cnt_r <= '0;
        end
      end

      assign filt_s = filt_r;
    end
  endgenerate

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_d_r <= 1'b1;
    end else begin
      lvl_d_r <= filt_s;
    end
  end

  assign lvl  = filt_s;
  assign rise = filt_s & ~lvl_d_r;
endmodule

module joy_db15_tx #(
  parameter int NBITS  = 32,
  parameter int FILT   = 2,
  parameter bit INVERT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  joy_db15_if.slave            link,
  input  logic [NBITS/2-1:0]   p1_btn,
  input  logic [NBITS/2-1:0]   p2_btn,
  output logic [6:0]           bit_cnt,
  output logic                 frame_done,
  output logic                 overrun
);
  logic             clk_lvl_s, clk_rise_s;
  logic             load_lvl_s, load_rise_s;
  logic [NBITS-1:0] sreg_r, sreg_nxt_s;
  logic [6:0]       cnt_r, cnt_nxt_s;
  logic             done_r, done_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             data_r, data_nxt_s;

  joy_db15_cond #(.FILT(FILT)) u_clk_cond (
    .clk(clk), .rst_n(rst_n), .pin(link.joy_clk), .lvl(clk_lvl_s), .rise(clk_rise_s)
  );

  joy_db15_cond #(.FILT(FILT)) u_load_cond (
    .clk(clk), .rst_n(rst_n), .pin(link.joy_load), .lvl(load_lvl_s), .rise(load_rise_s)
  );

  // Load is transparent while low; a clk rise coinciding with load release is dropped.
  always_comb begin
    sreg_nxt_s = sreg_r;
    cnt_nxt_s  = cnt_r;
    done_nxt_s = 1'b0;
    ovr_nxt_s  = 1'b0;
    if (!load_lvl_s) begin
      sreg_nxt_s = {p2_btn, p1_btn};
      cnt_nxt_s  = 7'd0;
    end else if (clk_rise_s && !load_rise_s) begin
      sreg_nxt_s = {1'b0, sreg_r[NBITS-1:1]};
      if (cnt_r == 7'(NBITS)) begin
        ovr_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s  = cnt_r + 7'd1;
        done_nxt_s = (cnt_r == 7'(NBITS - 1));
      end
    end else begin
      sreg_nxt_s = sreg_r;
    end
    data_nxt_s = INVERT ? ~sreg_nxt_s[0] : sreg_nxt_s[0];
  end

  // State and registered outputs; joy_data tracks the next sreg LSB so the
  // pin changes in the same cycle as the shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_r <= '0;
      cnt_r  <= 7'd0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      data_r <= INVERT;
    end else begin
      sreg_r <= sreg_nxt_s;
      cnt_r  <= cnt_nxt_s;
      done_r <= done_nxt_s;
      ovr_r  <= ovr_nxt_s;
      data_r <= data_nxt_s;
    end
  end

  assign link.joy_data = data_r;
  assign bit_cnt       = cnt_r;
  assign frame_done    = done_r;
  assign overrun       = ovr_r;
endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx (NBITS=32, FILT=2, INVERT=1).
module tb_joy_db15_tx;
  logic        clk;
  logic        rst_n;
  logic [15:0] p1_btn;
  logic [15:0] p2_btn;
  logic [6:0]  bit_cnt;
  logic        frame_done;
  logic        overrun;

  int checks;
  int errors;
  int done_cnt;
  int ovr_cnt;

  joy_db15_if link ();

  joy_db15_tx #(.NBITS(32), .FILT(2), .INVERT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .link(link.slave),
    .p1_btn(p1_btn), .p2_btn(p2_btn),
    .bit_cnt(bit_cnt), .frame_done(frame_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (overrun)    ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load();
    link.joy_load = 1'b0;
    tick(6);
    link.joy_load = 1'b1;
    tick(6);
  endtask

  // One poller clock pulse; data is sampled just before the rising edge.
  task automatic pulse(input bit do_chk, input logic exp_bit, input string tag);
    link.joy_clk = 1'b0;
    tick(4);
    if (do_chk) chk(tag, {63'd0, link.joy_data}, {63'd0, exp_bit});
    link.joy_clk = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [31:0] frame;
    int          d0;
    int          o0;
    int          lat;
    logic        prev;

    checks = 0; errors = 0; done_cnt = 0; ovr_cnt = 0;
    rst_n = 1'b0; p1_btn = 16'h0000; p2_btn = 16'h0000;
    link.joy_clk = 1'b1; link.joy_load = 1'b1;

    // 1. reset
    tick(4);
    chk("rst_data", {63'd0, link.joy_data}, 64'd1);
    chk("rst_cnt", {57'd0, bit_cnt}, 64'd0);
    chk("rst_pulses", 64'(done_cnt + ovr_cnt), 64'd0);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_data", {63'd0, link.joy_data}, 64'd1);
    chk("post_rst_cnt", {57'd0, bit_cnt}, 64'd0);

    // 2. full frame; buttons changed after load must not leak in
    p1_btn = 16'h0005; p2_btn = 16'h8000;
    frame = {16'h8000, 16'h0005};
    do_load();
    p1_btn = 16'hFFFF; p2_btn = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      pulse(1'b1, ~frame[i], $sformatf("bit%0d", i));
    end
    tick(4);
    chk("frame_cnt", {57'd0, bit_cnt}, 64'd32);
    chk("frame_done", 64'(done_cnt), 64'd1);
    chk("frame_ovr", 64'(ovr_cnt), 64'd0);

    // 3. overrun
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b1, $sformatf("ovr_data%0d", i));
    end
    tick(4);
    chk("ovr_pulses", 64'(ovr_cnt), 64'd3);
    chk("ovr_cnt_sat", {57'd0, bit_cnt}, 64'd32);
    chk("ovr_no_done", 64'(done_cnt), 64'd1);

    // 4. glitch filter
    p1_btn = 16'h0005; p2_btn = 16'h8000;
    do_load();
    chk("reload_cnt", {57'd0, bit_cnt}, 64'd0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, "");
    tick(2);
    chk("pre_glitch_cnt", {57'd0, bit_cnt}, 64'd3);
    link.joy_clk = 1'b0;
    tick(1);
    link.joy_clk = 1'b1;
    tick(10);
    chk("glitch_cnt", {57'd0, bit_cnt}, 64'd3);
    link.joy_clk = 1'b0;
    tick(3);
    link.joy_clk = 1'b1;
    tick(10);
    chk("pulse3_cnt", {57'd0, bit_cnt}, 64'd4);

    // 5. load precedence at bit_cnt=10
    for (int i = 0; i < 6; i++) pulse(1'b0, 1'b0, "");
    tick(2);
    chk("pre_load_cnt", {57'd0, bit_cnt}, 64'd10);
    chk("pre_load_data", {63'd0, link.joy_data}, 64'd1);
    d0 = done_cnt;
    p1_btn = 16'h0001;
    link.joy_clk = 1'b0;
    tick(6);
    link.joy_load = 1'b0;
    link.joy_clk  = 1'b1;
    tick(8);
    chk("load_win_cnt", {57'd0, bit_cnt}, 64'd0);
    chk("load_win_data", {63'd0, link.joy_data}, 64'd0);
    link.joy_clk = 1'b0;
    tick(6);
    link.joy_load = 1'b1;
    link.joy_clk  = 1'b1;
    tick(8);
    chk("release_cnt", {57'd0, bit_cnt}, 64'd0);
    chk("release_data", {63'd0, link.joy_data}, 64'd0);
    chk("release_no_done", 64'(done_cnt - d0), 64'd0);

    // 6. latency and mid-frame reset
    p1_btn = 16'h0081; p2_btn = 16'h0000;
    do_load();
    o0 = ovr_cnt;
    link.joy_clk = 1'b0;
    tick(4);
    prev = link.joy_data;
    chk("lat_bit0", {63'd0, prev}, 64'd0);
    link.joy_clk = 1'b1;
    lat = 99;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (link.joy_data !== prev) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd5);
    tick(4);
    for (int i = 0; i < 6; i++) pulse(1'b0, 1'b0, "");
    tick(2);
    chk("mid_cnt", {57'd0, bit_cnt}, 64'd7);
    chk("mid_data", {63'd0, link.joy_data}, 64'd0);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_data", {63'd0, link.joy_data}, 64'd1);
    chk("mid_rst_cnt", {57'd0, bit_cnt}, 64'd0);
    rst_n = 1'b1;
    tick(4);
    chk("mid_rst_no_ovr", 64'(ovr_cnt - o0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
